alu_req_arbiter: RTL and testbench

//  Shares one combinational ALU (8-bit operands, 12-bit result, 4-bit opsel) between two requesters.

---
 rtl/alu_req_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_alu_req_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// -----------------------------------------------------------------------------
// alu_req_arbiter
//
// Shares one external combinational ALU between two requesters. Requests are
// arbitrated round-robin and only one operation is in flight at a time. The
// operands and opcode that drive the ALU are registered and held. After
// ALU_LAT cycles the ALU result is captured and returned, tagged with the
// owner's ID.
//
// Handshakes (valid/ready on both request ports and on the response port):
//   A transfer happens on a rising clk edge where valid and ready are both
//   high. A producer that raises valid keeps valid and its payload stable
//   until that edge. Ready may depend combinationally on valid. The response
//   side holds rsp_valid/rsp_data/rsp_id/rsp_err stable until it is taken.
//   Dropping a request valid before ready has no effect.
//
// Optional feature macro: ALU_OPSEL_CHECK_EN
//   Defined   : an accepted opcode above 10 does not reach the ALU. It is
//               answered at once with rsp_err=1 and rsp_data=0.
//   Undefined : every opcode goes to the ALU and rsp_err is tied low.
//
// Ports
//   clk, rst_n             clock (rising edge), async active-low reset
//   req0_valid/ready/a/b/opsel   requester 0 operation
//   req1_valid/ready/a/b/opsel   requester 1 operation
//   alu_a, alu_b, alu_opsel      registered operands/opcode to the ALU
//   alu_result                   ALU result (MUL_WIDTH bits)
//   rsp_valid/ready/data/id/err  response to the consumer
//   busy                         high whenever the FSM is not IDLE
//
// Debug: the FSM state is the internal signal "state" (type state_t).
// -----------------------------------------------------------------------------
module alu_req_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MUL_WIDTH = 12,
  parameter int ALU_LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  input  logic [3:0]           req0_opsel,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  input  logic [3:0]           req1_opsel,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [3:0]           alu_opsel,
  input  logic [MUL_WIDTH-1:0] alu_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [MUL_WIDTH-1:0] rsp_data,
  output logic                 rsp_id,
  output logic                 rsp_err,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             last_grant;
  logic             grant;
  logic             accept;
  logic             bad_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [3:0]       sel_opsel;

  // Round-robin: a lone requester always wins. On a tie, the requester that
  // did not win last time wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign accept     = (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid && grant;

  assign sel_a     = grant ? req1_a     : req0_a;
  assign sel_b     = grant ? req1_b     : req0_b;
  assign sel_opsel = grant ? req1_opsel : req0_opsel;

`ifdef ALU_OPSEL_CHECK_EN
  assign bad_op = (sel_opsel > 4'd10);
`else
  assign bad_op = 1'b0;
`endif

  assign busy = (state != IDLE);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        // A rejected opcode has no ALU work, so it goes straight to RESP.
        if (accept) begin
          state_nxt = bad_op ? RESP : EXEC;
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opsel  <= '0;
      cnt        <= '0;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= grant;
            rsp_id     <= grant;
            if (bad_op) begin
              // The ALU inputs keep the previous op's values.
              rsp_valid <= 1'b1;
              rsp_data  <= '0;
            end else begin
              alu_a     <= sel_a;
              alu_b     <= sel_b;
              alu_opsel <= sel_opsel;
              cnt       <= CNT_LOAD;
            end
          end
        end
        EXEC: begin
          // The load value ALU_LAT-1 puts the capture edge exactly ALU_LAT
          // edges after the accept edge.
          if (cnt == '0) begin
            rsp_data  <= alu_result;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          // rsp_data and rsp_id keep their last values after the handshake.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_OPSEL_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err <= 1'b0;
    end else if (state == IDLE) begin
      if (accept && bad_op) begin
        rsp_err <= 1'b1;
      end
    end else if (state == RESP) begin
      if (rsp_ready) begin
        rsp_err <= 1'b0;
      end
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_req_arbiter
//
// Directed bench for alu_req_arbiter. Two instances share one clock and reset:
// u_dut uses ALU_LAT=1 and u_dut3 uses ALU_LAT=3. A small reference ALU
// (0 add, 1 sub, 2 mul, other opcodes 12'habc) answers each instance from its
// own alu_* outputs. Inputs are driven 1 ns after the rising edge. Outputs
// are checked after that, away from the edge.
// -----------------------------------------------------------------------------
module tb_alu_req_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ALU_LAT=1 instance
  logic        r0_valid, r0_ready, r1_valid, r1_ready;
  logic [7:0]  r0_a, r0_b, r1_a, r1_b;
  logic [3:0]  r0_op, r1_op;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_opsel;
  logic [11:0] alu_result;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [11:0] rsp_data;

  // ALU_LAT=3 instance
  logic        s_r0_valid, s_r0_ready, s_r1_valid, s_r1_ready;
  logic [7:0]  s_r0_a, s_r0_b, s_r1_a, s_r1_b;
  logic [3:0]  s_r0_op, s_r1_op;
  logic [7:0]  s_alu_a, s_alu_b;
  logic [3:0]  s_alu_opsel;
  logic [11:0] s_alu_result;
  logic        s_rsp_valid, s_rsp_ready, s_rsp_id, s_rsp_err, s_busy;
  logic [11:0] s_rsp_data;

  function automatic logic [11:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] op);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (op)
      4'd0:    return 12'(a) + 12'(b);
      4'd1:    return 12'(a) - 12'(b);
      4'd2:    return p[11:0];
      default: return 12'habc;
    endcase
  endfunction

  assign alu_result   = alu_model(alu_a, alu_b, alu_opsel);
  assign s_alu_result = alu_model(s_alu_a, s_alu_b, s_alu_opsel);

  alu_req_arbiter #(.WIDTH(8), .MUL_WIDTH(12), .ALU_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0_valid), .req0_ready(r0_ready), .req0_a(r0_a), .req0_b(r0_b), .req0_opsel(r0_op),
    .req1_valid(r1_valid), .req1_ready(r1_ready), .req1_a(r1_a), .req1_b(r1_b), .req1_opsel(r1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opsel(alu_opsel), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_err(rsp_err), .busy(busy)
  );

  alu_req_arbiter #(.WIDTH(8), .MUL_WIDTH(12), .ALU_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(s_r0_valid), .req0_ready(s_r0_ready), .req0_a(s_r0_a), .req0_b(s_r0_b), .req0_opsel(s_r0_op),
    .req1_valid(s_r1_valid), .req1_ready(s_r1_ready), .req1_a(s_r1_a), .req1_b(s_r1_b), .req1_opsel(s_r1_op),
    .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_opsel(s_alu_opsel), .alu_result(s_alu_result),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_data(s_rsp_data), .rsp_id(s_rsp_id),
    .rsp_err(s_rsp_err), .busy(s_busy)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for a response on the ALU_LAT=1 instance.
  task automatic wait_rsp(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    check({tag, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Hand-computed table for four back-to-back ops (ALU_LAT=1, rsp_ready=1).
  // Each op takes three cycles: IDLE, EXEC, RESP.
  bit          busy_exp [12] = '{0,1,1, 0,1,1, 0,1,1, 0,1,1};
  bit          rv_exp   [12] = '{0,0,1, 0,0,1, 0,0,1, 0,0,1};
  bit          id_exp   [4]  = '{0, 1, 0, 1};
  logic [11:0] d_exp    [4]  = '{12'd55, 12'd3713, 12'd55, 12'd3713};

  initial begin
    rst_n = 1'b0;
    r0_valid = 0; r0_a = 0; r0_b = 0; r0_op = 0;
    r1_valid = 0; r1_a = 0; r1_b = 0; r1_op = 0;
    rsp_ready = 0;
    s_r0_valid = 0; s_r0_a = 0; s_r0_b = 0; s_r0_op = 0;
    s_r1_valid = 0; s_r1_a = 0; s_r1_b = 0; s_r1_op = 0;
    s_rsp_ready = 0;

    // ---- reset values ----
    repeat (2) tick();
    check("rst_alu_a",     32'(alu_a),     32'd0);
    check("rst_alu_b",     32'(alu_b),     32'd0);
    check("rst_alu_opsel", 32'(alu_opsel), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(rsp_data),  32'd0);
    check("rst_rsp_id",    32'(rsp_id),    32'd0);
    check("rst_rsp_err",   32'(rsp_err),   32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    rst_n = 1'b1;
    tick();

    // ---- 1: single op on requester 0 ----
    r0_valid = 1; r0_a = 8'd118; r0_b = 8'd28; r0_op = 4'd0; rsp_ready = 1;
    #1;
    check("t1_r0_ready", 32'(r0_ready), 32'd1);
    check("t1_busy_idle", 32'(busy), 32'd0);
    tick();                       // accept edge
    r0_valid = 0;
    #1;
    check("t1_r0_ready_exec", 32'(r0_ready), 32'd0);
    check("t1_busy_exec", 32'(busy), 32'd1);
    check("t1_alu_a", 32'(alu_a), 32'd118);
    check("t1_alu_b", 32'(alu_b), 32'd28);
    check("t1_no_rsp_exec", 32'(rsp_valid), 32'd0);
    tick();                       // capture edge
    check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1_rsp_data", 32'(rsp_data), 32'd146);
    check("t1_rsp_id", 32'(rsp_id), 32'd0);
    tick();                       // handshake edge
    check("t1_rsp_done", 32'(rsp_valid), 32'd0);
    check("t1_busy_done", 32'(busy), 32'd0);
    check("t1_data_held", 32'(rsp_data), 32'd146);

    // ---- 2: tie after reset, requester 0 wins first ----
    do_reset();
    r0_valid = 1; r0_a = 8'd90; r0_b = 8'd35; r0_op = 4'd1;
    r1_valid = 1; r1_a = 8'd47; r1_b = 8'd79; r1_op = 4'd2;
    #1;
    check("t2_r0_ready", 32'(r0_ready), 32'd1);
    check("t2_r1_ready", 32'(r1_ready), 32'd0);
    tick();
    r0_valid = 0;
    wait_rsp("t2a", 4);
    check("t2a_data", 32'(rsp_data), 32'd55);
    check("t2a_id", 32'(rsp_id), 32'd0);
    tick();                       // handshake, back to IDLE
    check("t2_r1_ready", 32'(r1_ready), 32'd1);
    tick();
    r1_valid = 0;
    wait_rsp("t2b", 4);
    check("t2b_data", 32'(rsp_data), 32'd3713);
    check("t2b_id", 32'(rsp_id), 32'd1);
    tick();

    // ---- 4: both valid continuously for four ops ----
    r0_valid = 1; r0_a = 8'd90; r0_b = 8'd35; r0_op = 4'd1;
    r1_valid = 1; r1_a = 8'd47; r1_b = 8'd79; r1_op = 4'd2;
    #1;
    for (int k = 0; k < 12; k++) begin
      check($sformatf("t4_busy_%0d", k), 32'(busy), 32'(busy_exp[k]));
      check($sformatf("t4_rv_%0d", k), 32'(rsp_valid), 32'(rv_exp[k]));
      if (rv_exp[k]) begin
        check($sformatf("t4_id_%0d", k / 3), 32'(rsp_id), 32'(id_exp[k / 3]));
        check($sformatf("t4_data_%0d", k / 3), 32'(rsp_data), 32'(d_exp[k / 3]));
      end
      tick();
    end
    r0_valid = 0; r1_valid = 0;

    // ---- 3: consumer stalls in RESP while requester 1 waits ----
    rsp_ready = 0;
    r0_valid = 1; r0_a = 8'd10; r0_b = 8'd5; r0_op = 4'd0;
    #1;
    check("t3_r0_ready", 32'(r0_ready), 32'd1);
    tick();
    r0_valid = 0;
    r1_valid = 1; r1_a = 8'd3; r1_b = 8'd4; r1_op = 4'd2;
    #1;
    check("t3_r1_ready_exec", 32'(r1_ready), 32'd0);
    tick();                       // capture, now in RESP
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_hold_valid_%0d", i), 32'(rsp_valid), 32'd1);
      check($sformatf("t3_hold_data_%0d", i), 32'(rsp_data), 32'd15);
      check($sformatf("t3_hold_id_%0d", i), 32'(rsp_id), 32'd0);
      check($sformatf("t3_r1_blocked_%0d", i), 32'(r1_ready), 32'd0);
      tick();
    end
    rsp_ready = 1;
    #1;
    check("t3_r1_blocked_hs", 32'(r1_ready), 32'd0);
    tick();                       // handshake edge
    check("t3_rsp_cleared", 32'(rsp_valid), 32'd0);
    check("t3_r1_ready", 32'(r1_ready), 32'd1);
    tick();                       // requester 1 accepted
    r1_valid = 0;
    #1;
    check("t3_alu_a", 32'(alu_a), 32'd3);
    check("t3_alu_opsel", 32'(alu_opsel), 32'd2);
    wait_rsp("t3b", 4);
    check("t3b_data", 32'(rsp_data), 32'd12);
    check("t3b_id", 32'(rsp_id), 32'd1);
    tick();

    // ---- 5: out-of-range opcode 12 ----
    r0_valid = 1; r0_a = 8'd7; r0_b = 8'd9; r0_op = 4'd12;
    #1;
    check("t5_r0_ready", 32'(r0_ready), 32'd1);
    tick();
    r0_valid = 0;
    wait_rsp("t5", 4);
    check("t5_id", 32'(rsp_id), 32'd0);
`ifdef ALU_OPSEL_CHECK_EN
    check("t5_err", 32'(rsp_err), 32'd1);
    check("t5_data", 32'(rsp_data), 32'd0);
    check("t5_alu_opsel", 32'(alu_opsel), 32'd2);
    check("t5_alu_a", 32'(alu_a), 32'd3);
`else
    check("t5_err", 32'(rsp_err), 32'd0);
    check("t5_data", 32'(rsp_data), 32'habc);
    check("t5_alu_opsel", 32'(alu_opsel), 32'd12);
    check("t5_alu_a", 32'(alu_a), 32'd7);
`endif
    tick();
    check("t5_err_cleared", 32'(rsp_err), 32'd0);
    check("t5_rsp_cleared", 32'(rsp_valid), 32'd0);

    // ---- 6: ALU_LAT=3 latency, then reset during EXEC ----
    s_rsp_ready = 1;
    s_r1_valid = 1; s_r1_a = 8'd20; s_r1_b = 8'd22; s_r1_op = 4'd0;
    #1;
    check("t6_r1_ready", 32'(s_r1_ready), 32'd1);
    tick();                       // accept edge E0
    s_r1_valid = 0;
    #1;
    check("t6_no_rsp_e0", 32'(s_rsp_valid), 32'd0);
    tick();
    check("t6_no_rsp_e1", 32'(s_rsp_valid), 32'd0);
    tick();
    check("t6_no_rsp_e2", 32'(s_rsp_valid), 32'd0);
    tick();                       // E0+3 capture
    check("t6_rsp_valid", 32'(s_rsp_valid), 32'd1);
    check("t6_rsp_data", 32'(s_rsp_data), 32'd42);
    check("t6_rsp_id", 32'(s_rsp_id), 32'd1);
    tick();
    check("t6_rsp_done", 32'(s_rsp_valid), 32'd0);
    s_r0_valid = 1; s_r0_a = 8'd5; s_r0_b = 8'd6; s_r0_op = 4'd2;
    #1;
    check("t6_r0_ready", 32'(s_r0_ready), 32'd1);
    tick();                       // requester 0 accepted, last grant now 0
    s_r0_valid = 0;
    tick();                       // mid-EXEC
    check("t6_busy_exec", 32'(s_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_alu_a", 32'(s_alu_a), 32'd0);
    check("t6_rst_alu_b", 32'(s_alu_b), 32'd0);
    check("t6_rst_alu_opsel", 32'(s_alu_opsel), 32'd0);
    check("t6_rst_rsp_data", 32'(s_rsp_data), 32'd0);
    check("t6_rst_rsp_id", 32'(s_rsp_id), 32'd0);
    check("t6_rst_busy", 32'(s_busy), 32'd0);
    check("t6_rst_rsp_valid", 32'(s_rsp_valid), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t6_no_rsp_after_rst_%0d", i), 32'(s_rsp_valid), 32'd0);
    end
    s_r0_valid = 1; s_r1_valid = 1;
    #1;
    check("t6_grant_r0", 32'(s_r0_ready), 32'd1);
    check("t6_grant_not_r1", 32'(s_r1_ready), 32'd0);
    s_r0_valid = 0; s_r1_valid = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
